// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller: op encoding,
// controller state type and the iteration-counter width helper.
package muldiv_pkg;

    // Op codes presented on the op input alongside start.
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFixup
    } state_e;

    // Counter has to hold width-1; never let it collapse to zero bits.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int unsigned DefaultWidth = 32;
    localparam int unsigned DefaultCntW  = cnt_width(DefaultWidth);

endpackage

// File: rtl/muldiv_iter_dp.sv
// Iterative multiply/divide datapath: one shift-add (multiply, multiplier LSB
// first) or one restoring-division step per enabled cycle. Works on operand
// magnitudes only; sign handling lives in the controller.
module muldiv_iter_dp
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               step,
    input  logic               div_mode,
    input  logic [WIDTH-1:0]   rs_mag,
    input  logic [WIDTH-1:0]   rt_mag,
    output logic [2*WIDTH-1:0] prod,
    output logic [WIDTH-1:0]   quot,
    output logic [WIDTH-1:0]   rem,
    output logic               mul_rest_zero
);

    // opa: multiplicand (shifted left) or divisor in the low word.
    // opb: multiplier (shifted right) or dividend that becomes the quotient.
    // acc: product, or partial remainder in the low WIDTH+1 bits.
    logic [2*WIDTH-1:0] opa_q;
    logic [WIDTH-1:0]   opb_q;
    logic [2*WIDTH-1:0] acc_q;

    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] rem_diff;

    // Restoring trial subtraction; bit WIDTH of the difference is the borrow.
    always_comb begin
        rem_shift = {acc_q[WIDTH-1:0], opb_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, opa_q[WIDTH-1:0]};
    end

    // Operand load and per-cycle iteration step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opa_q <= '0;
            opb_q <= '0;
            acc_q <= '0;
        end else if (load) begin
            acc_q <= '0;
            if (div_mode) begin
                opa_q <= {{WIDTH{1'b0}}, rt_mag};
                opb_q <= rs_mag;
            end else begin
                opa_q <= {{WIDTH{1'b0}}, rs_mag};
                opb_q <= rt_mag;
            end
        end else if (step) begin
            if (div_mode) begin
                if (!rem_diff[WIDTH]) begin
                    acc_q <= {{(WIDTH-1){1'b0}}, rem_diff};
                    opb_q <= {opb_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_q <= {{(WIDTH-1){1'b0}}, rem_shift};
                    opb_q <= {opb_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                if (opb_q[0]) begin
                    acc_q <= acc_q + opa_q;
                end
                opa_q <= opa_q << 1;
                opb_q <= opb_q >> 1;
            end
        end
    end

    assign prod          = acc_q;
    assign quot          = opb_q;
    assign rem           = acc_q[WIDTH-1:0];
    // Multiplier bits left once the current LSB has been consumed.
    assign mul_rest_zero = (opb_q[WIDTH-1:1] == '0);

endmodule

// File: rtl/hi_lo_muldiv_ctrl.sv
// HI/LO register pair with an iterative MULT/MULTU/DIV/DIVU sequencer,
// single-cycle MTHI/MTLO and the pipeline stall request.
// Optional: define MULDIV_EARLY_OUT_EN to leave a multiply RUN as soon as the
// remaining multiplier bits are all zero.
module hi_lo_muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mf_req,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    state_e state_q, state_d;

    logic [CntW-1:0]  cnt_q;
    logic             is_div_q;
    logic             neg_res_q;
    logic             neg_rem_q;
    logic             div_zero_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q;

    logic             iter_op;
    logic             signed_op;
    logic             accept_iter;
    logic             rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_mag, rt_mag;
    logic             early_out;

    logic [2*WIDTH-1:0] dp_prod;
    logic [WIDTH-1:0]   dp_quot;
    logic [WIDTH-1:0]   dp_rem;
    logic               dp_rest_zero;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   res_hi, res_lo;

    // Op decode and operand magnitudes; unsigned ops pass raw values through.
    always_comb begin
        iter_op     = (op[2] == 1'b0);
        signed_op   = (op == OP_MULT) || (op == OP_DIV);
        accept_iter = (state_q == StIdle) && start && iter_op;
        rs_neg      = signed_op && rs_data[WIDTH-1];
        rt_neg      = signed_op && rt_data[WIDTH-1];
        rs_mag      = rs_neg ? (-rs_data) : rs_data;
        rt_mag      = rt_neg ? (-rt_data) : rt_data;
    end

`ifdef MULDIV_EARLY_OUT_EN
    assign early_out = !is_div_q && dp_rest_zero;
`else
    logic unused_rest_zero;
    assign unused_rest_zero = dp_rest_zero;
    assign early_out        = 1'b0;
`endif

    muldiv_iter_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk           (clk),
        .reset_n       (reset_n),
        .load          (accept_iter),
        .step          (state_q == StRun),
        .div_mode      (accept_iter ? op[1] : is_div_q),
        .rs_mag        (rs_mag),
        .rt_mag        (rt_mag),
        .prod          (dp_prod),
        .quot          (dp_quot),
        .rem           (dp_rem),
        .mul_rest_zero (dp_rest_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: WIDTH RUN cycles (fewer with early-out), then one FIXUP.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept_iter) state_d = StRun;
            StRun:   if ((cnt_q == '0) || early_out) state_d = StFixup;
            StFixup: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: busy for RUN and FIXUP; stall only holds ops that touch HI/LO.
    always_comb begin
        busy  = (state_q != StIdle);
        stall = busy && (start || mf_req);
    end

    // Iteration counter and sign/mode flags captured at acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else if (accept_iter) begin
            cnt_q      <= CntW'(WIDTH - 1);
            is_div_q   <= op[1];
            neg_res_q  <= rs_neg ^ rt_neg;
            neg_rem_q  <= rs_neg;
            div_zero_q <= (rt_data == '0);
        end else if ((state_q == StRun) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Sign fixup and result mapping. A zero divisor leaves |rs| as remainder,
    // so re-applying the dividend sign yields rs_data; only LO needs forcing.
    always_comb begin
        prod_fix = neg_res_q ? (-dp_prod) : dp_prod;
        quot_fix = neg_res_q ? (-dp_quot) : dp_quot;
        rem_fix  = neg_rem_q ? (-dp_rem) : dp_rem;
        if (is_div_q) begin
            res_hi = rem_fix;
            res_lo = div_zero_q ? '1 : quot_fix;
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

    // Architectural HI/LO: iterative results at FIXUP, moves only from IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state_q == StFixup) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
        end else if ((state_q == StIdle) && start) begin
            if (op == OP_MTHI) hi_q <= rs_data;
            if (op == OP_MTLO) lo_q <= rs_data;
        end
    end

    // Completion pulse, high the cycle after the FIXUP write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == StFixup);
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign done = done_q;

endmodule

// File: doc/hi_lo_muldiv_ctrl.md
Name: hi_lo_muldiv_ctrl

Overview:
- Sequencing controller for the HI/LO register pair and an iterative multiply/divide engine.
- Executes MULT, MULTU, DIV, DIVU over multiple cycles, and MTHI/MTLO in a single cycle.
- Holds the architectural HI/LO values and drives a stall request to the pipeline. Stall is raised when a HI/LO read or a new HI/LO-writing op arrives while a computation is in flight.
- Sits beside the decode/control unit, which supplies the op and the register-file read data.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; iterative ops take WIDTH RUN cycles.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  op valid this cycle (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
- op  input  3  op code, encoding from muldiv_pkg
- rs_data  input  WIDTH  rs operand (multiplicand, dividend, or MTHI/MTLO source)
- rt_data  input  WIDTH  rt operand (multiplier or divisor)
- mf_req  input  1  MFHI or MFLO in decode this cycle
- busy  output  1  iterative op in flight
- stall  output  1  pipeline hold request
- hi  output  WIDTH  architectural HI
- lo  output  WIDTH  architectural LO
- done  output  1  one-cycle pulse after HI/LO are updated by an iterative op

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, reset_n).
- Reset: state IDLE; hi=0, lo=0, busy=0, done=0, stall=0; all internal accumulators cleared.
- Reset asserted mid-operation: abandon the op immediately; HI/LO return to 0; no done pulse.
- States: IDLE, RUN, FIXUP.
- IDLE, start with an iterative op:
  - Latch |rs| and |rt| (raw values for the unsigned ops), plus the sign flags.
  - Load the iteration counter with WIDTH-1, go to RUN; busy=1 from the next cycle.
- IDLE, start with MTHI/MTLO: hi (or lo) <= rs_data at that edge; stays IDLE; busy never asserts; no done pulse.
- RUN, multiply:
  - Shift-add, one multiplier bit per cycle, LSB first, into a 2*WIDTH product register.
  - Counter decrements each cycle; at 0 go to FIXUP.
- RUN, divide:
  - Restoring division, one quotient bit per cycle.
  - Counter decrements each cycle; at 0 go to FIXUP.
- FIXUP, signed ops:
  - Product negated if the operand signs differ.
  - Quotient negated if the signs differ.
  - Remainder takes the sign of the dividend.
- FIXUP, result write: hi/lo written at the FIXUP edge; then IDLE, busy=0, and done=1 for exactly one cycle.
- Result mapping: multiply gives HI=upper word, LO=lower word. Divide gives LO=quotient, HI=remainder.
- Latency: busy is high for exactly WIDTH+1 cycles; new HI/LO are visible on the cycle done is high.
- Divide by zero, signed or unsigned: HI=rs_data, LO=all ones. Runs full latency; no exception.
- Signed INT_MIN / -1: LO=INT_MIN, HI=0.
- hi/lo hold their old values throughout RUN and FIXUP.
- stall = busy & (start | mf_req), combinational.
  - start while busy is not accepted; upstream holds the op until stall drops.
  - start in IDLE is always accepted with stall=0.
- Upstream must not assert start and mf_req together. If it does, start takes priority and mf_req sees the pre-op HI/LO.
- Unused op codes with start=1: ignored, no state change.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- With the macro: during a multiply RUN, if the remaining multiplier bits (after the current shift) are all zero, go to FIXUP on that edge. Minimum one RUN cycle. Divide is unaffected.
- Without the macro: multiply always runs WIDTH RUN cycles; latency is fixed at WIDTH+1.

Decomposition:
- muldiv_pkg contains:
  - op encoding: OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3, OP_MTHI=4, OP_MTLO=5;
  - a state enum (IDLE, RUN, FIXUP);
  - a helper constant for counter width, $clog2(WIDTH).
- One sub-module, muldiv_iter_dp: the shift-add/restore datapath (operand, accumulator and quotient registers, one step per enable). The FSM, sign fixup, HI/LO registers and stall logic stay in hi_lo_muldiv_ctrl.

Test Plan:
1. MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> busy 33 cycles, then HI=0xFFFFFFFE, LO=0x00000001, done pulse width 1.
2. MULT rs=0xFFFFFFFD (-3) rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV rs=-7 rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. DIVU rs=7 rt=0 -> HI=7, LO=0xFFFFFFFF. DIV rs=0x80000000 rt=0xFFFFFFFF -> LO=0x80000000, HI=0.
4. MULT in flight, mf_req=1 at cycle 5 -> stall=1 each cycle until done, stall=0 on the done cycle. MTHI rs=0x1234 while busy -> stall until IDLE; then HI=0x1234 one edge after acceptance, busy stays 0.
5. reset_n low at RUN cycle 10 of DIVU -> busy=0, HI=LO=0 asynchronously, no done pulse. After release, MTLO 0xA5 -> LO=0xA5.
6. With MULDIV_EARLY_OUT_EN: MULTU rs=5 rt=3 -> busy 3 cycles, LO=15, HI=0. Without the macro, the same op keeps busy for 33 cycles.
